// File: rtl/seq_mul_pkg.sv
// Shared types and helpers for the seq_mul sequential multiplier.
package seq_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mul_step.sv
// One shift-add iteration: optionally add/subtract a_ext into the upper
// accumulator, then shift the {acc_hi, acc_lo} pair right by one bit.
module seq_mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH:0]   a_ext_i,
  input  logic             bit_i,
  input  logic             subtract_i,
  input  logic             arith_i,
  output logic [WIDTH:0]   acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);

  logic [WIDTH:0] addend_s;
  logic [WIDTH:0] sum_s;
  logic           fill_s;

  assign addend_s = bit_i ? a_ext_i : {(WIDTH+1){1'b0}};
  assign sum_s    = subtract_i ? (acc_hi_i - addend_s) : (acc_hi_i + addend_s);
  // The extra accumulator bit keeps the signed sum exact, so its MSB is the true sign.
  assign fill_s   = arith_i ? sum_s[WIDTH] : 1'b0;

  assign acc_hi_o = {fill_s, sum_s[WIDTH:1]};
  assign acc_lo_o = {sum_s[0], acc_lo_i[WIDTH-1:1]};

endmodule

// File: rtl/seq_mul.sv
// Sequential shift-add multiplier with valid/ready on both sides.
// Define SEQ_MUL_SIGNED_EN to honour signed_op (two's-complement operands).
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH:0]     acc_hi_q;
  logic [WIDTH-1:0]   acc_lo_q;
  logic [WIDTH:0]     acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_d;
  logic [2*WIDTH-1:0] p_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               last_s;
  logic [WIDTH:0]     a_ext_s;
  logic               subtract_s;
  logic               arith_s;

  assign last_s = (cnt_q == CNT_W'(WIDTH - 1));

`ifdef SEQ_MUL_SIGNED_EN
  logic signed_q;

  // MSB of b carries negative weight, hence the subtract on the final step.
  assign a_ext_s    = {signed_q & a_q[WIDTH-1], a_q};
  assign subtract_s = signed_q & last_s;
  assign arith_s    = signed_q;
`else
  logic unused_signed_op_s;

  assign unused_signed_op_s = signed_op;
  assign a_ext_s    = {1'b0, a_q};
  assign subtract_s = 1'b0;
  assign arith_s    = 1'b0;
`endif

  seq_mul_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_hi_i   (acc_hi_q),
    .acc_lo_i   (acc_lo_q),
    .a_ext_i    (a_ext_s),
    .bit_i      (b_q[0]),
    .subtract_i (subtract_s),
    .arith_i    (arith_s),
    .acc_hi_o   (acc_hi_d),
    .acc_lo_o   (acc_lo_d)
  );

  // Control FSM and datapath registers; b_q shifts so bit 0 is always b[cnt].
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      acc_hi_q    <= {(WIDTH+1){1'b0}};
      acc_lo_q    <= {WIDTH{1'b0}};
      p_q         <= {(2*WIDTH){1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      signed_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            acc_hi_q   <= {(WIDTH+1){1'b0}};
            acc_lo_q   <= {WIDTH{1'b0}};
            cnt_q      <= {CNT_W{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= ST_RUN;
`ifdef SEQ_MUL_SIGNED_EN
            signed_q   <= signed_op;
`endif
          end
        end
        ST_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          b_q      <= {1'b0, b_q[WIDTH-1:1]};
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_s) begin
            p_q         <= {acc_hi_d[WIDTH-1:0], acc_lo_d};
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          cnt_q       <= {CNT_W{1'b0}};
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_seq_mul.sv
// Scoreboard bench for seq_mul: WIDTH=4 directed cases and WIDTH=16 random ops.
module tb_seq_mul;

`ifdef SEQ_MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4_n, in_valid4, in_ready4, s4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        rst16_n, in_valid16, in_ready16, s16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks_cnt = 0;
  int failures_cnt = 0;
  int cyc = 0;

  logic [31:0] exp4_q[$];
  logic [31:0] exp16_q[$];
  int          t4_q[$];
  int          t16_q[$];
  bit          ov4_prev = 1'b0;
  bit          ov16_prev = 1'b0;

  seq_mul #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_op(s4), .out_valid(out_valid4),
    .out_ready(out_ready4), .p(p4)
  );

  seq_mul #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_op(s16), .out_valid(out_valid16),
    .out_ready(out_ready16), .p(p16)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    longint sa, sb, pr;
    sa = longint'({48'd0, a});
    sb = longint'({48'd0, b});
    if (s && SIGNED_EN) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    pr = sa * sb;
    return 32'(pr & ((longint'(1) << (2 * w)) - longint'(1)));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for the 4-bit instance: push on accept, compare on transfer.
  always @(negedge clk) begin
    if (rst4_n === 1'b1) begin
      if (in_valid4 && in_ready4) begin
        exp4_q.push_back(model(4, {12'd0, a4}, {12'd0, b4}, s4));
        t4_q.push_back(cyc + 1);
      end
      if (out_valid4 && !ov4_prev && t4_q.size() > 0)
        check_eq("lat4", 64'(cyc - t4_q[0]), 64'd4);
      if (out_valid4 && out_ready4) begin
        if (exp4_q.size() == 0) check_eq("spurious4", 64'd1, 64'd0);
        else begin
          check_eq("p4", 64'(p4), 64'(exp4_q.pop_front()));
          void'(t4_q.pop_front());
        end
      end
    end
    ov4_prev = (out_valid4 === 1'b1);
  end

  // Scoreboard for the 16-bit instance.
  always @(negedge clk) begin
    if (rst16_n === 1'b1) begin
      if (in_valid16 && in_ready16) begin
        exp16_q.push_back(model(16, a16, b16, s16));
        t16_q.push_back(cyc + 1);
      end
      if (out_valid16 && !ov16_prev && t16_q.size() > 0)
        check_eq("lat16", 64'(cyc - t16_q[0]), 64'd16);
      if (out_valid16 && out_ready16) begin
        if (exp16_q.size() == 0) check_eq("spurious16", 64'd1, 64'd0);
        else begin
          check_eq("p16", 64'(p16), 64'(exp16_q.pop_front()));
          void'(t16_q.pop_front());
        end
      end
    end
    ov16_prev = (out_valid16 === 1'b1);
  end

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b1; a4 = a; b4 = b; s4 = s;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready4) begin ok = 1'b1; break; end
    end
    check_eq("accept4", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0; a4 = ~a; b4 = ~b; s4 = ~s;
  endtask

  task automatic wait_done4();
    bit ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (out_valid4 && out_ready4) begin ok = 1'b1; break; end
    end
    check_eq("done4", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid16 = 1'b1; a16 = a; b16 = b; s16 = s;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready16) begin ok = 1'b1; break; end
    end
    check_eq("accept16", 64'(ok), 64'd1);
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~s;
  endtask

  task automatic wait_done16();
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (out_valid16 && out_ready16) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      out_ready16 = 1'($urandom_range(0, 1));
    end
    check_eq("done16", 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  // Directed table entries are {signed_op, a, b}.
  logic [8:0] dir_tbl [8] = '{
    {1'b0, 4'hF, 4'hF}, {1'b1, 4'h8, 4'h8}, {1'b1, 4'h8, 4'h7}, {1'b1, 4'h7, 4'hF},
    {1'b1, 4'hF, 4'h2}, {1'b0, 4'h8, 4'h8}, {1'b0, 4'h0, 4'h9}, {1'b1, 4'hF, 4'hF}
  };

  initial begin
    logic [15:0] ra, rb;
    rst4_n = 1'b0; in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; s4 = 1'b0; out_ready4 = 1'b1;
    rst16_n = 1'b0; in_valid16 = 1'b0; a16 = 16'd0; b16 = 16'd0; s16 = 1'b0; out_ready16 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready4", 64'(in_ready4), 64'd1);
    check_eq("rst_out_valid4", 64'(out_valid4), 64'd0);
    check_eq("rst_p4", 64'(p4), 64'd0);
    check_eq("rst_in_ready16", 64'(in_ready16), 64'd1);
    check_eq("rst_out_valid16", 64'(out_valid16), 64'd0);
    check_eq("rst_p16", 64'(p16), 64'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1; rst16_n = 1'b1;

    foreach (dir_tbl[i]) begin
      send4(dir_tbl[i][7:4], dir_tbl[i][3:0], dir_tbl[i][8]);
      wait_done4();
    end

    // Backpressure: product held, new operands ignored, then one transfer.
    out_ready4 = 1'b0;
    send4(4'd5, 4'd9, 1'b0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid4) break;
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid4 = k[0]; a4 = 4'($urandom); b4 = 4'($urandom); s4 = 1'b0;
      @(negedge clk);
      check_eq("bp_p4", 64'(p4), 64'h2D);
      check_eq("bp_out_valid4", 64'(out_valid4), 64'd1);
      check_eq("bp_in_ready4", 64'(in_ready4), 64'd0);
    end
    @(posedge clk); #1;
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    wait_done4();
    @(negedge clk);
    check_eq("bp_idle_in_ready4", 64'(in_ready4), 64'd1);
    check_eq("bp_idle_out_valid4", 64'(out_valid4), 64'd0);

    // Reset two cycles into RUN discards the operation.
    send4(4'd9, 4'd9, 1'b0);
    @(posedge clk); #1;
    rst4_n = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b1;
    exp4_q.delete(); t4_q.delete();
    @(negedge clk);
    check_eq("mr_in_ready4", 64'(in_ready4), 64'd1);
    check_eq("mr_out_valid4", 64'(out_valid4), 64'd0);
    check_eq("mr_p4", 64'(p4), 64'd0);
    send4(4'd3, 4'd5, 1'b0);
    wait_done4();
    check_eq("mr_next_p4", 64'(p4), 64'd15);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 100 == 0) begin ra = 16'h8000; rb = 16'h8000; end
      if (i % 100 == 1) begin ra = 16'h7FFF; rb = 16'h8000; end
      if (i % 100 == 2) begin ra = 16'hFFFF; rb = 16'hFFFF; end
      send16(ra, rb, 1'($urandom_range(0, 1)));
      wait_done16();
    end

    @(negedge clk);
    check_eq("drain4", 64'(exp4_q.size()), 64'd0);
    check_eq("drain16", 64'(exp16_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
